// File: rtl/leaf_pkt_pkg.sv
// Shared types and default widths for the leaf router packetizer.
package leaf_pkt_pkg;

    localparam int unsigned DEST_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 3;
    localparam int unsigned TAIL_BIT   = DEST_W_DEF;
    localparam int unsigned STATS_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/leaf_packetizer.sv
// Wraps a request (dest, len) plus len+1 payload words into a header flit and a tail-terminated body.
// Optional packet counter output pkt_count when LEAF_PACKETIZER_STATS_EN is defined.
module leaf_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DEST_W-1:0] req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [DEST_W-1:0] word_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [DEST_W:0]   flit_data,
`ifdef LEAF_PACKETIZER_STATS_EN
    output logic [STATS_W-1:0] pkt_count,
`endif
    output logic              busy
);

    pkt_state_e        state_q, state_nx;
    logic [DEST_W-1:0] dest_q, dest_nx;
    logic [LEN_W-1:0]  len_q, len_nx;
    logic [LEN_W-1:0]  cnt_q, cnt_nx;
    logic              tail_c;
    logic              tail_xfer_c;

    // State and request-context registers
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            dest_q  <= dest_nx;
            len_q   <= len_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // Next-state and handshake outputs; everything forced low while reset is asserted
    always_comb begin
        state_nx    = state_q;
        dest_nx     = dest_q;
        len_nx      = len_q;
        cnt_nx      = cnt_q;
        req_ready   = 1'b0;
        flit_valid  = 1'b0;
        word_ready  = 1'b0;
        flit_data   = '0;
        busy        = 1'b0;
        tail_c      = 1'b0;
        tail_xfer_c = 1'b0;
        if (_RESET) begin
            case (state_q)
                ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        dest_nx  = req_dest;
                        len_nx   = req_len;
                        cnt_nx   = '0;
                        state_nx = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    busy       = 1'b1;
                    flit_valid = 1'b1;
                    flit_data  = {1'b0, dest_q};
                    if (flit_ready) begin
                        state_nx = ST_BODY;
                    end
                end
                ST_BODY: begin
                    busy       = 1'b1;
                    tail_c     = (cnt_q == len_q);
                    flit_valid = word_valid;
                    word_ready = flit_ready;
                    flit_data  = {tail_c, word_data};
                    if (word_valid && flit_ready) begin
                        cnt_nx      = cnt_q + LEN_W'(1);
                        tail_xfer_c = tail_c;
                        if (tail_c) begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

`ifdef LEAF_PACKETIZER_STATS_EN
    // Completed-packet counter, wraps naturally at its width
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            pkt_count <= '0;
        end else if (tail_xfer_c) begin
            pkt_count <= pkt_count + STATS_W'(1);
        end
    end
`else
    logic unused_tail_xfer;
    assign unused_tail_xfer = tail_xfer_c;
`endif

endmodule

// File: tb/tb_leaf_packetizer.sv
// Self-checking bench for leaf_packetizer with a queue-based flit reference model.
module tb_leaf_packetizer;
    import leaf_pkt_pkg::*;

    localparam int unsigned DW = DEST_W_DEF;
    localparam int unsigned LW = LEN_W_DEF;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_dest;
    logic [LW-1:0] req_len;
    logic          word_valid;
    logic          word_ready;
    logic [DW-1:0] word_data;
    logic          flit_valid;
    logic          flit_ready;
    logic [DW:0]   flit_data;
    logic          busy;
`ifdef LEAF_PACKETIZER_STATS_EN
    logic [15:0]   pkt_count;
`endif

    int total = 0;
    int bad   = 0;
    int exp_pkts = 0;

    leaf_packetizer #(.DEST_W(DW), .LEN_W(LW)) dut (
        .CLK        (clk),
        ._RESET     (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
`ifdef LEAF_PACKETIZER_STATS_EN
        .pkt_count  (pkt_count),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_dest   = '0;
        req_len    = '0;
        word_valid = 1'b0;
        word_data  = '0;
        flit_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b1;
        req_dest   = 8'hFF;
        req_len    = 3'd5;
        word_valid = 1'b1;
        word_data  = 8'h77;
        flit_ready = 1'b1;
        repeat (3) step();
        #1;
        total++;
        if ({req_ready, flit_valid, word_ready, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outs: got rr/fv/wr/busy=%b want 0000", {req_ready, flit_valid, word_ready, busy});
        end
        total++;
        if (flit_data !== 9'h000) begin
            bad++;
            $display("FAIL reset_flit_data: got %h want 000", flit_data);
        end
        idle_inputs();
        reset_n = 1'b1;
        step();
        #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got req_ready=%b busy=%b want 1 0", req_ready, busy);
        end
        exp_pkts = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        req_valid = 1'b1; req_dest = 8'h11; req_len = 3'd3; flit_ready = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = 8'(8'h40 + i);
            word_valid = (i > 0); word_data = w;
            step();
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (flit_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_low: got flit_valid=%b busy=%b want 0 0", flit_valid, busy);
        end
        step();
        #1;
        total++;
        if (flit_valid !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_after: got fv=%b busy=%b wr=%b want 0 0 0", flit_valid, busy, word_ready);
        end
        idle_inputs();
        reset_n = 1'b1;
        step();
        #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || flit_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_release: got rr=%b busy=%b fv=%b want 1 0 0", req_ready, busy, flit_valid);
        end
`ifdef LEAF_PACKETIZER_STATS_EN
        total++;
        if (pkt_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset_count: got %0d want 0", pkt_count);
        end
`endif
        exp_pkts = 0;
    endtask

    task automatic test_single();
        req_valid = 1'b1; req_dest = 8'hA5; req_len = 3'd0; flit_ready = 1'b1; word_valid = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || flit_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got rr=%b fv=%b want 1 0", req_ready, flit_valid);
        end
        step();
        req_valid = 1'b0; word_valid = 1'b1; word_data = 8'h3C;
        #1;
        total++;
        if (flit_valid !== 1'b1 || flit_data !== 9'h0A5 || word_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_head: got fv=%b data=%h wr=%b want 1 0a5 0", flit_valid, flit_data, word_ready);
        end
        step();
        #1;
        total++;
        if (flit_valid !== 1'b1 || flit_data !== 9'h13C || word_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_body: got fv=%b data=%h wr=%b want 1 13c 1", flit_valid, flit_data, word_ready);
        end
        step();
        word_valid = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || flit_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle_after: got busy=%b rr=%b fv=%b want 0 1 0", busy, req_ready, flit_valid);
        end
        exp_pkts++;
    endtask

    task automatic test_max_len();
        logic [8:0] want;
        req_valid = 1'b1; req_dest = 8'h5A; req_len = 3'd7; flit_ready = 1'b1;
        step();
        req_valid = 1'b0;
        #1;
        total++;
        if (flit_valid !== 1'b1 || flit_data !== 9'h05A) begin
            bad++;
            $display("FAIL max_head: got fv=%b data=%h want 1 05a", flit_valid, flit_data);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            word_valid = 1'b1; word_data = 8'(i);
            want = {(i == 7) ? 1'b1 : 1'b0, 8'(i)};
            #1;
            total++;
            if (flit_valid !== 1'b1 || flit_data !== want) begin
                bad++;
                $display("FAIL max_body%0d: got fv=%b data=%h want 1 %h", i, flit_valid, flit_data, want);
            end
            step();
        end
        word_valid = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL max_end: got busy=%b rr=%b want 0 1", busy, req_ready);
        end
        exp_pkts++;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_dest = 8'hC1; req_len = 3'd1; flit_ready = 1'b1; word_valid = 1'b1;
        word_data = 8'hD0;
        step();
        req_dest = 8'hC2; req_len = 3'd0;
        // head plus two body cycles: request must be refused throughout
        for (int i = 0; i < 3; i++) begin
            word_data = 8'(8'hD0 + i);
            #1;
            total++;
            if (req_ready !== 1'b0 || flit_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_busy%0d: got rr=%b fv=%b want 0 1", i, req_ready, flit_valid);
            end
            step();
        end
        #1;
        total++;
        if (req_ready !== 1'b1 || flit_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got rr=%b fv=%b want 1 0", req_ready, flit_valid);
        end
        step();
        req_valid = 1'b0; word_data = 8'hE7;
        #1;
        total++;
        if (flit_valid !== 1'b1 || flit_data !== 9'h0C2) begin
            bad++;
            $display("FAIL b2b_head2: got fv=%b data=%h want 1 0c2", flit_valid, flit_data);
        end
        step();
        #1;
        total++;
        if (flit_data !== 9'h1E7) begin
            bad++;
            $display("FAIL b2b_tail2: got %h want 1e7", flit_data);
        end
        step();
        idle_inputs();
        exp_pkts += 2;
    endtask

    task automatic test_random_stalls();
        logic [8:0] exp_q[$];
        bit         hdr_q[$];
        logic [7:0] wq[$];
        logic [7:0] rdest[100];
        logic [2:0] rlen[100];
        logic [8:0] held;
        bit         hdr_stalled;
        int         ri;
        int         cyc;
        for (int p = 0; p < 100; p++) begin
            rdest[p] = 8'($urandom);
            rlen[p]  = 3'($urandom_range(0, 7));
            exp_q.push_back({1'b0, rdest[p]});
            hdr_q.push_back(1'b1);
            for (int k = 0; k <= int'(rlen[p]); k++) begin
                logic [7:0] w;
                w = 8'($urandom);
                wq.push_back(w);
                exp_q.push_back({(k == int'(rlen[p])) ? 1'b1 : 1'b0, w});
                hdr_q.push_back(1'b0);
            end
        end
        ri = 0;
        cyc = 0;
        hdr_stalled = 1'b0;
        held = '0;
        while (exp_q.size() > 0 && cyc < 20000) begin
            req_valid  = (ri < 100);
            req_dest   = (ri < 100) ? rdest[ri] : 8'($urandom);
            req_len    = (ri < 100) ? rlen[ri] : 3'($urandom);
            word_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
            word_data  = (wq.size() > 0) ? wq[0] : 8'($urandom);
            flit_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (hdr_stalled) begin
                total++;
                if (flit_valid !== 1'b1 || flit_data !== held) begin
                    bad++;
                    $display("FAIL rnd_hdr_hold: got fv=%b data=%h want 1 %h", flit_valid, flit_data, held);
                end
            end
            hdr_stalled = 1'b0;
            if (flit_valid === 1'b1 && flit_ready) begin
                total++;
                if (flit_data !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rnd_flit: got %h want %h (left %0d)", flit_data, exp_q[0], exp_q.size());
                end
                void'(exp_q.pop_front());
                void'(hdr_q.pop_front());
            end else if (flit_valid === 1'b1 && hdr_q[0]) begin
                hdr_stalled = 1'b1;
                held = flit_data;
            end
            if (req_valid && req_ready === 1'b1) ri++;
            if (word_valid && word_ready === 1'b1) void'(wq.pop_front());
            step();
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rnd_timeout: got %0d flits outstanding want 0", exp_q.size());
        end
        idle_inputs();
        step();
        #1;
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rnd_end_idle: got busy=%b rr=%b want 0 1", busy, req_ready);
        end
        exp_pkts += 100;
    endtask

`ifdef LEAF_PACKETIZER_STATS_EN
    task automatic test_stats();
        #1;
        total++;
        if (pkt_count !== 16'(exp_pkts)) begin
            bad++;
            $display("FAIL stats_count: got %0d want %0d", pkt_count, exp_pkts);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_reset_mid();
        test_single();
        test_max_len();
        test_back_to_back();
        test_random_stalls();
`ifdef LEAF_PACKETIZER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leaf_packetizer.md
LEAF_PACKETIZER -- requirements
Module: leaf_packetizer

Interface
REQ-001 Parameter DEST_W, default 8: destination-address width; SHALL equal flit payload width.
REQ-002 Parameter LEN_W, default 3: packet-length field width; body length = req_len+1 words (1..2**LEN_W).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 _RESET  input  1  synchronous, active-low reset, sampled on CLK rising edge.
REQ-005 req_valid  input  1  packet request present.
REQ-006 req_ready  output  1  packetizer can accept a request.
REQ-007 req_dest  input  DEST_W  destination address carried in header flit.
REQ-008 req_len  input  LEN_W  body word count minus one.
REQ-009 word_valid  input  1  payload word present.
REQ-010 word_ready  output  1  payload word consumed this cycle when word_valid also high.
REQ-011 word_data  input  DEST_W  payload word.
REQ-012 flit_valid  output  1  flit presented to leaf router input channel converter.
REQ-013 flit_ready  input  1  downstream accepts flit this cycle.
REQ-014 flit_data  output  DEST_W+1  bit[DEST_W] = tail, bits[DEST_W-1:0] = address or payload.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, HEAD, BODY; SHALL transition only on CLK edges.
REQ-017 IDLE: req_ready=1, flit_valid=0, word_ready=0; on req_valid, latch req_dest/req_len, clear body counter, go HEAD next cycle.
REQ-018 HEAD: req_ready=0, flit_valid=1, flit_data={1'b0, latched dest}; on flit_ready go BODY; else hold with data unchanged.
REQ-019 BODY: flit_valid=word_valid, word_ready=flit_ready, flit_data={tail, word_data}, tail=(counter==latched len).
REQ-020 BODY transfer occurs when word_valid && flit_ready; counter increments on each transfer.
REQ-021 Transfer with tail=1 SHALL return FSM to IDLE; next request acceptable the cycle after (one-cycle gap minimum between packets).
REQ-022 Header flit latency: flit_valid asserted exactly one cycle after request handshake.
REQ-023 Counter LEN_W bits wide; never wraps since tail terminates at counter==len; len=2**LEN_W-1 yields max packet of 2**LEN_W body flits.
REQ-024 Header flit never has tail=1; every packet has exactly one tail flit, its last.
REQ-025 word_data ignored and word_ready low outside BODY; req_* ignored outside IDLE.
REQ-026 Stalls (flit_ready low) of any length SHALL neither drop nor duplicate flits.

Reset
REQ-027 _RESET low at a clock edge: state=IDLE, counter=0, latched dest/len=0, regardless of state (including mid-packet; partial packet abandoned).
REQ-028 While _RESET low: req_ready=0, flit_valid=0, word_ready=0, busy=0, flit_data=0.
REQ-029 First cycle after reset release: req_ready=1.

Configuration
REQ-030 Macro LEAF_PACKETIZER_STATS_EN defined: extra output pkt_count (16 bits) SHALL increment on each tail-flit transfer, wrap 16'hFFFF->0, reset to 0.
REQ-031 Macro undefined: pkt_count port and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package leaf_pkt_pkg SHALL hold the state enum, flit-field index constant TAIL_BIT, and default widths.
REQ-033 Single module, no sub-modules; optional stats counter in same file under the macro.

Verification
REQ-034 Reset mid-BODY after 2 of 4 words -> next cycle flit_valid=0, busy=0; after release req_ready=1, pkt_count=0.
REQ-035 req_dest=8'hA5, req_len=0, word 8'h3C, flit_ready=1 -> flits {0,A5} then {1,3C}; back in IDLE 3 cycles after request.
REQ-036 req_len=7, words 0..7, flit_ready always 1 -> header + 8 body flits, tail only on word 7.
REQ-037 Random flit_ready/word_valid stalls over 100 packets -> scoreboard sees exact payload order, one tail per packet, header data stable while stalled.
REQ-038 req_valid held high during packet -> req_ready stays 0 until IDLE; second packet header follows after one-cycle gap.
REQ-039 STATS_EN build, 65537 single-word packets -> pkt_count=1.
